sum_accumulator: RTL
====================

# sum_accumulator

Downstream consumer of the registered CLA adder output. Accepts a stream of IN_WIDTH-bit sums under a valid/ready handshake, accumulates COUNT of them (or fewer on flush) into an ACC_WIDTH-bit total, and presents each total with a sample count and overflow flag on an output valid/ready handshake. The integration supplies in_valid by delaying the operand valid by the adder's two register stages.

## Interface
- IN_WIDTH, 5: width of each incoming sum (adder WIDTH+1)
- ACC_WIDTH, 12: accumulator and result width
- COUNT, 8: samples per result; legal range 2..255
- clock  input  1  single clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_sum carries a valid sample
- in_sum  input  IN_WIDTH  unsigned sample
- in_ready  output  1  block can accept a sample this cycle
- flush  input  1  close the current block early; single-cycle pulse
- out_valid  output  1  out_acc, out_cnt and out_ovf are valid
- out_ready  input  1  downstream accepts the result
- out_acc  output  ACC_WIDTH  accumulated total, modulo 2^ACC_WIDTH
- out_cnt  output  8  number of samples in out_acc
- out_ovf  output  1  a carry out of ACC_WIDTH occurred during the block

## Operation
- States: ACCUM and HOLD. Reset enters ACCUM.
- In ACCUM, in_ready=1. A sample is accepted when in_valid&&in_ready.
- On accept: acc <= acc + zero-extended in_sum; cnt <= cnt+1; ovf <= ovf | carry out of ACC_WIDTH.
- Block completes on the accept that brings cnt to COUNT, or on flush with cnt>0.
- Completion: out_acc, out_cnt and out_ovf load the final values, including any sample accepted in the same cycle. out_valid<=1. acc, cnt and ovf clear. State goes to HOLD.
- Flush and accept in the same cycle: the sample is included, then the block completes.
- Flush with cnt=0 and no accept: ignored, no empty result is emitted.
- Flush in HOLD: ignored.
- In HOLD, in_ready=0 and samples are not accepted. On out_valid&&out_ready, out_valid<=0 and state returns to ACCUM.
- out_acc, out_cnt and out_ovf are stable while out_valid=1 and out_ready=0.
- Wrap-around: acc wraps modulo 2^ACC_WIDTH. out_ovf reports the wrap and is never saturating.

## Timing
- Reset (reset_n low, asynchronous):
  - state=ACCUM; acc=0, cnt=0, ovf=0
  - out_valid=0, out_acc=0, out_cnt=0, out_ovf=0
  - in_ready=1 after release
- Reset mid-block or mid-HOLD discards all partial and pending data.
- in_ready is a combinational decode of state only. It has no path from in_valid, out_ready or flush.
- Latency: out_valid rises the cycle after the completing accept (or flush).
- Throughput:
  - One sample per cycle in ACCUM.
  - In HOLD, in_ready is low for at least 1 cycle.
  - With out_ready held high: COUNT accept cycles, then 1 HOLD cycle per result.
- out_ready in the same cycle out_valid rises has no effect, because out_valid is not yet visible. The handshake completes on the first edge where both out_valid and out_ready are high.

## Test plan
- Reset, then 8 accepted samples of value 3 back-to-back, out_ready=1:
  - out_valid for 1 cycle
  - out_acc=24, out_cnt=8, out_ovf=0
  - in_ready low exactly 1 cycle
- 8 samples of 31 with ACC_WIDTH=7: out_acc=248 mod 128=120, out_ovf=1.
- Flush cases:
  - 3 samples (5,10,16), then flush alone -> out_acc=31, out_cnt=3.
  - Flush with cnt=0 -> no out_valid.
  - Flush on the same cycle as a 4th sample of 2 -> out_acc=33, out_cnt=4.
- Backpressure:
  - Complete a block with out_ready=0 for 5 cycles, in_valid held high.
  - in_ready stays 0, outputs stay constant, no samples are lost.
  - The next block starts the cycle after the handshake.
- Random in_valid and out_ready over 10,000 samples: results match a reference model sum per block, and the sum of out_cnt equals the number of accepted samples.
- Assert reset_n low mid-block (cnt=5) and during HOLD:
  - All outputs go to 0 immediately.
  - After release, the next 8 samples of 1 give out_acc=8.

Source files
------------

// File: rtl/sum_accumulator.sv
// Accumulates COUNT incoming sums (or fewer on flush) into one total and
// presents it with a sample count and wrap flag under a valid/ready handshake.
module sum_accumulator #(
   parameter int IN_WIDTH  = 5,
   parameter int ACC_WIDTH = 12,
   parameter int COUNT     = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 in_valid,
   input  logic [IN_WIDTH-1:0]  in_sum,
   output logic                 in_ready,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_acc,
   output logic [7:0]           out_cnt,
   output logic                 out_ovf
);

   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [7:0]           cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;
   logic                 out_valid_q, out_valid_d;
   logic [ACC_WIDTH-1:0] out_acc_q, out_acc_d;
   logic [7:0]           out_cnt_q, out_cnt_d;
   logic                 out_ovf_q, out_ovf_d;

   logic                 accept;
   logic                 done;
   logic [ACC_WIDTH:0]   sum_ext;
   logic [ACC_WIDTH-1:0] acc_nxt;
   logic [7:0]           cnt_nxt;
   logic                 ovf_nxt;

   // in_ready depends on state alone so it never combinationally loops back
   // through the upstream valid logic.
   assign in_ready  = (state_q == ACCUM);
   assign out_valid = out_valid_q;
   assign out_acc   = out_acc_q;
   assign out_cnt   = out_cnt_q;
   assign out_ovf   = out_ovf_q;

   always_comb begin
      accept  = in_valid && (state_q == ACCUM);
      sum_ext = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, in_sum};
      acc_nxt = acc_q;
      cnt_nxt = cnt_q;
      ovf_nxt = ovf_q;
      if (accept) begin
         acc_nxt = sum_ext[ACC_WIDTH-1:0];
         cnt_nxt = cnt_q + 8'd1;
         ovf_nxt = ovf_q | sum_ext[ACC_WIDTH];
      end
      // A flush only closes a block that holds at least one sample, counting
      // a sample accepted on the same edge.
      done = (state_q == ACCUM) &&
             ((accept && (cnt_nxt == 8'(COUNT))) ||
              (flush && (cnt_nxt != 8'd0)));
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_nxt;
      cnt_d       = cnt_nxt;
      ovf_d       = ovf_nxt;
      out_valid_d = out_valid_q;
      out_acc_d   = out_acc_q;
      out_cnt_d   = out_cnt_q;
      out_ovf_d   = out_ovf_q;
      case (state_q)
         ACCUM: begin
            if (done) begin
               out_acc_d   = acc_nxt;
               out_cnt_d   = cnt_nxt;
               out_ovf_d   = ovf_nxt;
               out_valid_d = 1'b1;
               acc_d       = '0;
               cnt_d       = '0;
               ovf_d       = 1'b0;
               state_d     = HOLD;
            end
         end
         HOLD: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_acc_q   <= '0;
         out_cnt_q   <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_acc_q   <= out_acc_d;
         out_cnt_q   <= out_cnt_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

endmodule
